coverfloat_scan_sched: RTL
==========================

# coverfloat_scan_sched

Shared, multi-cycle bit-pattern scanner with a round-robin scheduler for the coverfloat coverage collectors. Up to NUM_REQ requesters (e.g. per-operand and intermediate-significand coverpoint samplers) submit a value and width. The block grants one request at a time and scans it CHUNK bits per cycle. It returns leading/trailing zero/one counts and the longest run of ones to feed the leading-zero, trailing-ones and run-length coverpoints. A single time-shared engine replaces per-sampler combinational 256-bit count logic.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CHUNK, 8, bits consumed per scan cycle (power of two, 1..64)
- MAX_W, 256, maximum scan width; fixed at 256

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_val  in  NUM_REQ*256  value per requester; slice i = [i*256 +: 256]
- req_width  in  NUM_REQ*9  width per requester, 0..256; slice i = [i*9 +: 9]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(NUM_REQ)  index of the requester served
- rsp_lz, rsp_lo, rsp_tz, rsp_to, rsp_lrun  out  9 each  leading zeros, leading ones, trailing zeros, trailing ones, longest run of ones

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - If any req_valid is high, pick the first set index strictly after last_grant, wrapping.
  - Assert req_ready for that index only, in the same cycle (combinational from req_valid and state).
  - Latch value, width and id; clear the accumulators; go to SCAN.
  - last_grant resets to NUM_REQ-1, so requester 0 wins the first arbitration.
- SCAN:
  - Each cycle consumes bits [k*CHUNK +: CHUNK], k = 0,1,..., LSB to MSB.
  - Bits at index >= width are ignored, not counted.
  - tz/to grow while all processed bits are 0/1 respectively.
  - A running zero-run and one-run counter resets on the opposite bit. At completion, lz = final zero-run and lo = final one-run, both ending at bit width-1.
  - lrun = running maximum of the one-run.
  - Last chunk is k = ceil(width/CHUNK)-1. After it: go to DONE and update last_grant.
- DONE:
  - rsp_valid = 1; rsp_* hold stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. No grant occurs in that cycle.
- width = 0: one scan cycle, all counts 0.
- width > 256: treated as 256.
- Requesters hold req_valid, req_val and req_width stable until granted. Values are sampled only in the grant cycle.

## Timing
- Reset values:
  - state = IDLE, req_ready = 0, rsp_valid = 0, rsp_id = 0, all rsp counts = 0, last_grant = NUM_REQ-1, accumulators = 0.
- Latency: grant in cycle T, rsp_valid high in cycle T+1+max(1, ceil(width/CHUNK)).
  - With CHUNK=8: width 8 gives T+2; width 256 gives T+33.
- Throughput: one request per (scan cycles + 2) when rsp_ready is held high. The bubble comes from DONE->IDLE.
- Backpressure: DONE holds indefinitely; no further grant while DONE.
- Reset asserted mid-SCAN or in DONE:
  - The in-flight scan is discarded and outputs return to reset values asynchronously.
  - Nothing is granted until rst is released, then the next clock edge.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that stays valid is served within NUM_REQ grants.

## Structure
- Add to the shared coverfloat package:
  - SCAN_MAX_W = 256
  - scan_state_t enum {IDLE, SCAN, DONE}
  - scan_result_t packed struct {lz, lo, tz, to, lrun}, 9 bits each
- Sub-module coverfloat_scan_engine: the chunk accumulator datapath, with start/chunk-valid/last inputs and a scan_result_t output.
- The top level holds the arbiter, the FSM and the operand latch.

## Test plan
- Req 0, width 8, val 0x0F (CHUNK=8):
  - req_ready[0] in the grant cycle; rsp_valid 2 cycles later.
  - rsp_id=0, lz=4, lo=0, tz=0, to=4, lrun=4.
- Req 2, width 12, val 0xFFF0A:
  - Upper bits ignored; effective value 0xF0A.
  - lz=0, lo=4, tz=1, to=0, lrun=4.
- Width 256, all ones:
  - lo=to=lrun=256, lz=tz=0.
  - rsp_valid 33 cycles after grant.
- All four req_valid held high, rsp_ready=1:
  - Grants in order 0,1,2,3,0.
  - req_ready is one-hot every grant cycle.
- rsp_ready held low 5 cycles in DONE:
  - rsp_valid and rsp_* stable.
  - No req_ready while held.
  - Grant resumes one cycle after the rsp handshake.
- rst pulsed at cycle 10 of a width-256 scan:
  - rsp_valid=0 immediately.
  - After release, request 0 is granted first and its result is correct.

Source files
------------

// File: rtl/coverfloat_scan_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coverfloat_scan_sched_pkg
//  Description : Shared types and constants for the coverfloat bit-pattern
//                scanner (FSM state encoding, packed result record).
//  Revision    : 1.0 - initial release
// ============================================================================
package coverfloat_scan_sched_pkg;

  // Widest value any sampler may submit; counts therefore need 9 bits.
  localparam int SCAN_MAX_W = 256;
  localparam int SCAN_CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [SCAN_CNT_W-1:0] lz;
    logic [SCAN_CNT_W-1:0] lo;
    logic [SCAN_CNT_W-1:0] tz;
    logic [SCAN_CNT_W-1:0] to;
    logic [SCAN_CNT_W-1:0] lrun;
  } scan_result_t;

endpackage
`default_nettype wire

// File: rtl/coverfloat_scan_sched_engine.sv
`default_nettype none
// ============================================================================
//  Module      : coverfloat_scan_engine
//  Description : Chunk accumulator datapath. Consumes up to CHUNK bits per
//                cycle, LSB first, and maintains trailing counts, the running
//                zero/one runs and the longest one-run seen so far.
//  Revision    : 1.0 - initial release
// ============================================================================
module coverfloat_scan_engine
  import coverfloat_scan_sched_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   chunk_valid,
  input  logic [CHUNK-1:0]       chunk_bits,
  input  logic [$clog2(CHUNK):0] chunk_nbits,
  input  logic                   last,
  output scan_result_t           result,
  output logic                   result_valid
);

  localparam int NB_W = $clog2(CHUNK) + 1;

  logic [SCAN_CNT_W-1:0] tz_q, to_q, zrun_q, orun_q, lrun_q;
  logic                  all_zero_q, all_one_q;

  logic [SCAN_CNT_W-1:0] tz_n, to_n, zrun_n, orun_n, lrun_n;
  logic                  all_zero_n, all_one_n;

  // Walk the valid bits of this chunk in order, updating every counter as if
  // the bits arrived one at a time; bits past chunk_nbits are beyond width.
  always_comb begin
    tz_n       = tz_q;
    to_n       = to_q;
    zrun_n     = zrun_q;
    orun_n     = orun_q;
    lrun_n     = lrun_q;
    all_zero_n = all_zero_q;
    all_one_n  = all_one_q;
    for (int j = 0; j < CHUNK; j++) begin
      if (NB_W'(j) < chunk_nbits) begin
        if (chunk_bits[j]) begin
          orun_n     = orun_n + 9'd1;
          zrun_n     = '0;
          all_zero_n = 1'b0;
          if (all_one_n) to_n = to_n + 9'd1;
          if (orun_n > lrun_n) lrun_n = orun_n;
        end else begin
          zrun_n    = zrun_n + 9'd1;
          orun_n    = '0;
          all_one_n = 1'b0;
          if (all_zero_n) tz_n = tz_n + 9'd1;
        end
      end
    end
  end

  // Accumulator registers: cleared on start, advanced on each valid chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tz_q         <= '0;
      to_q         <= '0;
      zrun_q       <= '0;
      orun_q       <= '0;
      lrun_q       <= '0;
      all_zero_q   <= 1'b0;
      all_one_q    <= 1'b0;
      result_valid <= 1'b0;
    end else if (start) begin
      tz_q         <= '0;
      to_q         <= '0;
      zrun_q       <= '0;
      orun_q       <= '0;
      lrun_q       <= '0;
      all_zero_q   <= 1'b1;
      all_one_q    <= 1'b1;
      result_valid <= 1'b0;
    end else if (chunk_valid) begin
      tz_q       <= tz_n;
      to_q       <= to_n;
      zrun_q     <= zrun_n;
      orun_q     <= orun_n;
      lrun_q     <= lrun_n;
      all_zero_q <= all_zero_n;
      all_one_q  <= all_one_n;
      if (last) result_valid <= 1'b1;
    end
  end

  // Runs still open at the final bit (width-1) are the leading counts.
  assign result.lz   = zrun_q;
  assign result.lo   = orun_q;
  assign result.tz   = tz_q;
  assign result.to   = to_q;
  assign result.lrun = lrun_q;

endmodule
`default_nettype wire

// File: rtl/coverfloat_scan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : coverfloat_scan_sched
//  Description : Round-robin scheduler in front of one time-shared bit-pattern
//                scan engine. Grants one requester at a time, latches its
//                operand and scans it CHUNK bits per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module coverfloat_scan_sched
  import coverfloat_scan_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CHUNK   = 8,
  parameter int MAX_W   = SCAN_MAX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*MAX_W-1:0]     req_val,
  input  logic [NUM_REQ*9-1:0]         req_width,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [8:0]                   rsp_lz,
  output logic [8:0]                   rsp_lo,
  output logic [8:0]                   rsp_tz,
  output logic [8:0]                   rsp_to,
  output logic [8:0]                   rsp_lrun
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int NB_W   = $clog2(CHUNK) + 1;
  localparam int LOG2C  = $clog2(CHUNK);
  localparam int K_W    = (MAX_W / CHUNK > 1) ? $clog2(MAX_W / CHUNK) : 1;

  scan_state_t         state, next_state;
  logic [ID_W-1:0]     last_grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_valid;
  logic                grant_fire;

  logic [MAX_W-1:0]    val_q;
  logic [8:0]          width_q;
  logic [ID_W-1:0]     id_q;
  logic [K_W-1:0]      k_q;

  logic [MAX_W-1:0]    sel_val;
  logic [8:0]          sel_width;

  logic [9:0]          base;
  logic [9:0]          rem;
  logic [NB_W-1:0]     nbits;
  logic [CHUNK-1:0]    chunk_bits;
  logic                last;

  scan_result_t        result;
  logic                result_valid;

  // Round-robin pick: first valid index strictly after the previous winner.
  always_comb begin
    int idx;
    any_valid = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && req_valid[ID_W'(idx)]) begin
        any_valid = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  // Operand mux for the winner; oversized widths saturate at MAX_W.
  always_comb begin
    logic [8:0] w;
    sel_val = '0;
    w       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_val = req_val[i*MAX_W +: MAX_W];
        w       = req_width[i*9 +: 9];
      end
    end
    sel_width = (w > 9'(MAX_W)) ? 9'(MAX_W) : w;
  end

  // Current chunk window: its bits, how many of them lie below width, and
  // whether it is the final chunk (width 0 still takes one empty chunk).
  always_comb begin
    base       = 10'(k_q) << LOG2C;
    rem        = {1'b0, width_q} - base;
    nbits      = (rem >= 10'(CHUNK)) ? NB_W'(CHUNK) : NB_W'(rem);
    chunk_bits = CHUNK'(val_q >> base);
    last       = (base + 10'(CHUNK)) >= {1'b0, width_q};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next-state and grant; no grant is offered while reset is held.
  always_comb begin
    next_state = state;
    req_ready  = '0;
    grant_fire = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && !rst) begin
          req_ready[grant_idx] = 1'b1;
          grant_fire           = 1'b1;
          next_state           = SCAN;
        end
      end
      SCAN: begin
        if (last) next_state = DONE;
      end
      DONE: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, chunk counter and arbitration history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q      <= '0;
      width_q    <= '0;
      id_q       <= '0;
      k_q        <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (grant_fire) begin
      val_q   <= sel_val;
      width_q <= sel_width;
      id_q    <= grant_idx;
      k_q     <= '0;
    end else if (state == SCAN) begin
      k_q <= k_q + 1'b1;
      if (last) last_grant <= id_q;
    end
  end

  coverfloat_scan_engine #(
    .CHUNK (CHUNK)
  ) u_engine (
    .clk          (clk),
    .rst          (rst),
    .start        (grant_fire),
    .chunk_valid  (state == SCAN),
    .chunk_bits   (chunk_bits),
    .chunk_nbits  (nbits),
    .last         (last),
    .result       (result),
    .result_valid (result_valid)
  );

  assign rsp_valid = (state == DONE) && result_valid;
  assign rsp_id    = id_q;
  assign rsp_lz    = result.lz;
  assign rsp_lo    = result.lo;
  assign rsp_tz    = result.tz;
  assign rsp_to    = result.to;
  assign rsp_lrun  = result.lrun;

endmodule
`default_nettype wire
